// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
// Imported by the interface, the storage array and the FIFO top.
package sync_fifo_pkg;

  // Address width that never collapses to zero for tiny depths.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // An idle FIFO is empty and therefore also almost empty.
  localparam fifo_status_t FIFO_STATUS_RST = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer side of the FIFO: requests, data and status.
// The FIFO owns the slave modport; the user logic drives the master modport.
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = clog2_safe(DEPTH) + 1;

  logic              clr;
  logic              wr_en;
  logic [DATA_W-1:0] wdata;
  logic              rd_en;
  logic [DATA_W-1:0] rdata;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, wr_en, wdata, rd_en,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, wdata, rd_en,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; the FIFO pointers decide which words are meaningful.
module fifo_mem_2p
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = clog2_safe(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with thresholds, occupancy count, error pulses,
// synchronous flush and optional first-word-fall-through read.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_param_if.slave bus
);

  localparam int AW = clog2_safe(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] AF_C = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C = PW'(AE_THRESH);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
  end

  if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_chk_thresh
    $error("sync_fifo_param: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr_n;
  logic [PW-1:0]     rd_ptr_n;
  logic [PW-1:0]     count_q;
  logic [PW-1:0]     count_n;
  fifo_status_t      status_q;
  fifo_status_t      status_n;
  logic              wr_accept;
  logic              rd_accept;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // A full FIFO still takes a write when the same edge frees a slot.
  always_comb begin
    rd_accept = bus.rd_en && !status_q.empty;
    wr_accept = bus.wr_en && (!status_q.full || rd_accept);

    wr_ptr_n = wr_ptr + PW'(wr_accept);
    rd_ptr_n = rd_ptr + PW'(rd_accept);
    count_n  = count_q + PW'(wr_accept) - PW'(rd_accept);

    status_n              = FIFO_STATUS_RST;
    status_n.full         = (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]) &&
                            (wr_ptr_n[AW] != rd_ptr_n[AW]);
    status_n.empty        = (wr_ptr_n == rd_ptr_n);
    status_n.almost_full  = (count_n >= AF_C);
    status_n.almost_empty = (count_n <= AE_C);
    status_n.overflow     = bus.wr_en && !wr_accept;
    status_n.underflow    = bus.rd_en && !rd_accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      status_q <= FIFO_STATUS_RST;
    end else if (bus.clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      status_q <= FIFO_STATUS_RST;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      count_q  <= count_n;
      status_q <= status_n;
    end
  end

  assign mem_we = wr_accept && !bus.clr;

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (bus.wdata),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (mem_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word is always presented; it is only meaningful while not empty.
    assign bus.rdata = mem_rdata;
  end else begin : g_std
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (!bus.clr && rd_accept) begin
        rdata_q <= mem_rdata;
      end
    end

    assign bus.rdata = rdata_q;
  end

  assign bus.full         = status_q.full;
  assign bus.empty        = status_q.empty;
  assign bus.almost_full  = status_q.almost_full;
  assign bus.almost_empty = status_q.almost_empty;
  assign bus.overflow     = status_q.overflow;
  assign bus.underflow    = status_q.underflow;
  assign bus.count        = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: a standard-read instance driven through
// fill/drain/wrap/flush/reset sequences and a fall-through instance for head timing.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) a_if ();
  sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) b_if ();

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)
  ) u_std (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)
  ) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the standard instance (state after the latest edge)
  int         m_cnt   = 0;
  logic [7:0] m_q[$];
  logic [7:0] m_rdata = 8'h00;
  logic       m_ovf   = 1'b0;
  logic       m_udf   = 1'b0;

  // Scoreboard queues: expected read data in order
  logic [7:0] exp_a[$];
  logic [7:0] exp_f[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endfunction

  // {count, full, empty, almost_full, almost_empty, overflow, underflow, rdata}
  function automatic void chk_status(string tag);
    logic [31:0] act;
    logic [31:0] exp;
    act = {13'd0, a_if.count, a_if.full, a_if.empty, a_if.almost_full,
           a_if.almost_empty, a_if.overflow, a_if.underflow, a_if.rdata};
    exp = {13'd0, 5'(m_cnt), (m_cnt == 16), (m_cnt == 0), (m_cnt >= 14),
           (m_cnt <= 2), m_ovf, m_udf, m_rdata};
    chk({tag, "_status"}, act, exp);
  endfunction

  // Standard-read monitor: data is due the cycle after an accepted read.
  logic a_rd_pend = 1'b0;

  always @(posedge clk) begin
    a_rd_pend <= a_if.rd_en && !a_if.empty && !a_if.clr && !rst;
  end

  always @(negedge clk) begin
    if (a_rd_pend) begin
      if (exp_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL std_rdata_unexpected: actual 0x%0h required none", a_if.rdata);
      end else begin
        chk("std_rdata", 32'(a_if.rdata), 32'(exp_a.pop_front()));
      end
    end
  end

  // Fall-through monitor: the head is presented whenever not empty.
  always @(posedge clk) begin
    if (b_if.rd_en && !b_if.empty && !b_if.clr && !rst && exp_f.size() > 0) begin
      void'(exp_f.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && !b_if.empty) begin
      if (exp_f.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL fwft_head_unexpected: actual 0x%0h required none", b_if.rdata);
      end else begin
        chk("fwft_head", 32'(b_if.rdata), 32'(exp_f[0]));
      end
    end
  end

  task automatic step_a(string tag, logic w, logic [7:0] d, logic r, logic c);
    logic racc;
    logic wacc;
    a_if.wr_en = w;
    a_if.wdata = d;
    a_if.rd_en = r;
    a_if.clr   = c;
    racc = r && (m_cnt > 0);
    wacc = w && ((m_cnt < 16) || racc);
    if (c) begin
      m_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (racc) begin
        m_rdata = m_q.pop_front();
        exp_a.push_back(m_rdata);
      end
      if (wacc) m_q.push_back(d);
      m_cnt = m_q.size();
      m_ovf = w && !wacc;
      m_udf = r && !racc;
    end
    @(posedge clk);
    @(negedge clk);
    chk_status(tag);
  endtask

  task automatic step_b(string tag, logic w, logic [7:0] d, logic r,
                        logic exp_empty, int exp_cnt);
    b_if.wr_en = w;
    b_if.wdata = d;
    b_if.rd_en = r;
    if (w) exp_f.push_back(d);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_empty"}, 32'(b_if.empty), 32'(exp_empty));
    chk({tag, "_count"}, 32'(b_if.count), 32'(exp_cnt));
    // {full, almost_full, almost_empty, overflow, underflow}: count stays <= 1 here
    chk({tag, "_flags"}, 32'({b_if.full, b_if.almost_full, b_if.almost_empty,
                              b_if.overflow, b_if.underflow}), 32'h4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr_left;
    int rd_left;
    int wr_idx;
    int iter;
    logic w;
    logic r;

    a_if.clr = 1'b0; a_if.wr_en = 1'b0; a_if.rd_en = 1'b0; a_if.wdata = 8'h00;
    b_if.clr = 1'b0; b_if.wr_en = 1'b0; b_if.rd_en = 1'b0; b_if.wdata = 8'h00;

    #1 rst = 1'b1;
    #2;
    chk_status("reset");
    chk("fwft_reset_empty", 32'(b_if.empty), 32'd1);
    chk("fwft_reset_count", 32'(b_if.count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Fill to full, then one rejected write
    for (int i = 0; i < 16; i++) step_a("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    step_a("overflow", 1'b1, 8'hFF, 1'b0, 1'b0);
    step_a("ovf_clear", 1'b0, 8'h00, 1'b0, 1'b0);

    // Drain, then one rejected read with rdata holding the last word
    for (int i = 0; i < 16; i++) step_a("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    step_a("underflow", 1'b0, 8'h00, 1'b1, 1'b0);
    step_a("udf_clear", 1'b0, 8'h00, 1'b0, 1'b0);

    // Simultaneous write/read while full and while empty
    for (int i = 0; i < 16; i++) step_a("refill", 1'b1, 8'(8'h20 + 8'(i)), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step_a("full_wr_rd", 1'b1, 8'(8'h30 + 8'(i)), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step_a("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
    step_a("empty_wr_rd", 1'b1, 8'h40, 1'b1, 1'b0);
    step_a("read_40", 1'b0, 8'h00, 1'b1, 1'b0);
    step_a("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Random interleave across several pointer wraps
    wr_left = 40;
    rd_left = 40;
    wr_idx  = 0;
    iter    = 0;
    while ((wr_left > 0 || rd_left > 0) && iter < 2000) begin
      w = (wr_left > 0) && (m_cnt < 16) && ($urandom_range(0, 1) == 1);
      r = (rd_left > 0) && (m_cnt > 0) && ($urandom_range(0, 1) == 1);
      step_a("wrap", w, 8'(8'h80 + 8'(wr_idx)), r, 1'b0);
      if (w) begin wr_left--; wr_idx++; end
      if (r) rd_left--;
      iter++;
    end
    if (iter >= 2000) begin
      n_tests++;
      n_fail++;
      $display("FAIL wrap_budget: actual %0d reads left required 0", rd_left);
    end
    step_a("idle2", 1'b0, 8'h00, 1'b0, 1'b0);

    // Flush at count 9 with both requests asserted
    for (int i = 0; i < 9; i++) step_a("pre_clr", 1'b1, 8'(8'h50 + 8'(i)), 1'b0, 1'b0);
    step_a("clr", 1'b1, 8'hEE, 1'b1, 1'b1);
    step_a("post_clr", 1'b0, 8'h00, 1'b0, 1'b0);

    // Fall-through instance
    step_b("f_wr_a5", 1'b1, 8'hA5, 1'b0, 1'b0, 1);
    step_b("f_hold", 1'b0, 8'h00, 1'b0, 1'b0, 1);
    step_b("f_pop", 1'b0, 8'h00, 1'b1, 1'b1, 0);
    step_b("f_wr_11", 1'b1, 8'h11, 1'b0, 1'b0, 1);
    step_b("f_wr_rd", 1'b1, 8'h22, 1'b1, 1'b0, 1);
    step_b("f_pop2", 1'b0, 8'h00, 1'b1, 1'b1, 0);
    b_if.rd_en = 1'b0;

    // Asynchronous reset in the middle of a write burst
    for (int i = 0; i < 4; i++) step_a("burst", 1'b1, 8'(8'h60 + 8'(i)), 1'b1, 1'b0);
    a_if.wr_en = 1'b1;
    a_if.wdata = 8'h6F;
    #2 rst = 1'b1;
    #1;
    m_q.delete();
    m_cnt   = 0;
    m_rdata = 8'h00;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    chk_status("rst_async");
    @(negedge clk);
    a_if.wr_en = 1'b0;
    a_if.rd_en = 1'b0;
    rst = 1'b0;
    step_a("post_rst", 1'b0, 8'h00, 1'b0, 1'b0);

    chk("std_scoreboard_drained", 32'(exp_a.size()), 32'd0);
    chk("fwft_scoreboard_drained", 32'(exp_f.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
